cvxif_copro_responder: RTL
==========================

Name: cvxif_copro_responder

Overview:
- Coprocessor-side (responder) end of the core's CV-X-IF offload interface, enabled when CvxifEn=1.
- Accepts or rejects issued custom-3 instructions and executes accepted ones after a fixed latency.
- Buffers accepted instructions in order until the core commits or kills them, then returns results in order with ready/valid backpressure.
- Used as the reference coprocessor in core-level simulation and FPGA builds.

Parameters:
XLEN, 64, operand/result width
IdWidth, 3, transaction id width (log2 of NrScoreboardEntries=8)
Depth, 4, in-flight entry capacity (power of two, >=2)
Latency, 2, execute cycles from issue handshake to result-ready (>=1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
issue_valid_i  in  1  issue request valid
issue_ready_o  out  1  issue request ready
issue_instr_i  in  32  instruction word
issue_id_i  in  IdWidth  transaction id
issue_rs1_i  in  XLEN  source operand 1
issue_rs2_i  in  XLEN  source operand 2
issue_rs_valid_i  in  2  operand valid flags {rs2,rs1}
issue_accept_o  out  1  decision, valid during the issue handshake
issue_writeback_o  out  1  instruction will write rd
commit_valid_i  in  1  commit/kill message valid, no handshake
commit_id_i  in  IdWidth  id being committed
commit_kill_i  in  1  1 = discard, 0 = commit
result_valid_o  out  1  result valid
result_ready_i  in  1  result ready
result_id_o  out  IdWidth  result id
result_data_o  out  XLEN  result value
result_rd_o  out  5  destination register
result_we_o  out  1  write enable

Behaviour:
- Reset (async assert, sync deassert): FIFO empty, all counters 0. issue_ready_o=1 (reset state is empty). result_valid_o=0; result_id_o, result_data_o, result_rd_o, result_we_o=0. Reset mid-operation drops all in-flight entries; no results are emitted for them.
- Decode (combinational on issue_instr_i). An instruction matches when opcode[6:0]=7'b1111011 and funct7[31:25]=0. Operation by funct3:
  - 000: rs1+rs2, writeback=1
  - 001: rs1-rs2, writeback=1
  - 010: rs1^rs2, writeback=1
  - 011: NOP, writeback=0, operands not needed
  - other values: no match
- issue_accept_o = match AND (operand flags required by the op are all 1). issue_writeback_o = issue_accept_o AND op writes rd. Arithmetic is XLEN-bit modulo 2^XLEN.
- issue_ready_o = (count < Depth). It does not consider a same-cycle pop.
- Issue handshake = issue_valid_i AND issue_ready_o.
  - Rejected: completes in the same cycle, nothing is enqueued.
  - Accepted: enqueue {id, rd=instr[11:7], data, we, cnt=Latency, committed=0, killed=0}. The result is computed at issue and held for Latency cycles.
- Per entry, cnt decrements each cycle while nonzero.
- Commit: when commit_valid_i is high, the oldest uncommitted valid entry whose id matches commit_id_i sets committed=1, or killed=1 if commit_kill_i=1. A commit for an id not in the FIFO is ignored. A commit arriving in the same cycle as that id's issue handshake also applies to the new entry.
- Head handling:
  - Killed: popped silently once cnt=0; no result.
  - Committed with cnt=0: result_valid_o=1 with head fields.
  - Pop on result_valid_o AND result_ready_i.
- Once asserted, result_valid_o and all result fields hold stable until the handshake.
- Minimum latency: issue at cycle t, committed by t+Latency-1, result_ready_i=1 → result_valid_o high in cycle t+Latency.
- Push and pop in the same cycle are legal; count is unchanged.
- Pointers wrap modulo Depth.
- Full (count=Depth): issue_ready_o=0, so the core stalls the issue.

Test Plan:
- Reset values: reset asserted mid-stream with 3 entries → result_valid_o=0 and issue_ready_o=1 immediately; no result appears after release.
- Basic ADD: issue instr=32'h0000_007B|rd=5<<7, funct3=000, rs1=3, rs2=4, id=2 at t; commit id=2 at t; ready=1 → accept=1, writeback=1, result at t+2: id=2, rd=5, data=7, we=1.
- Reject: opcode 7'b0110011 or funct3=111 → accept=0, no enqueue, no result. ADD with rs_valid=2'b01 → accept=0.
- Kill and ordering: issue ids 1,2,3 (SUB 0-1, XOR, NOP); kill id 2; commit 1 and 3 → results id1 data=64'hFFFF_FFFF_FFFF_FFFF, then id3 with we=0. Nothing is emitted for id2.
- Backpressure/full: issue 4 ADDs all committed, result_ready_i=0 → issue_ready_o=0 on the 5th; fields stable 10 cycles; raise ready → in-order drain of 4, issue_ready_o returns to 1.
- Late commit: commit arrives 5 cycles after issue → result_valid_o asserts the cycle after commit is seen, not earlier.

Source files
------------

// File: rtl/cvxif_copro_responder.sv
// ----------------------------------------------------------------------------
// cvxif_copro_responder
//   Coprocessor (responder) side of the CV-X-IF offload interface. Decodes
//   custom-3 instructions (ADD/SUB/XOR/NOP), accepts or rejects them during
//   the issue handshake, and keeps accepted ones in an in-order buffer until
//   the core commits or kills them. Committed entries whose execute latency
//   has elapsed are returned in order over a ready/valid result channel.
//
// Ports
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   issue_*               issue request (valid/ready), decision and writeback
//   commit_*              commit/kill message (no handshake)
//   result_*              in-order result channel (valid/ready)
// ----------------------------------------------------------------------------
module cvxif_copro_responder #(
    parameter int XLEN    = 64,
    parameter int IdWidth = 3,
    parameter int Depth   = 4,
    parameter int Latency = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               issue_valid_i,
    output logic               issue_ready_o,
    input  logic [31:0]        issue_instr_i,
    input  logic [IdWidth-1:0] issue_id_i,
    input  logic [XLEN-1:0]    issue_rs1_i,
    input  logic [XLEN-1:0]    issue_rs2_i,
    input  logic [1:0]         issue_rs_valid_i,
    output logic               issue_accept_o,
    output logic               issue_writeback_o,
    input  logic               commit_valid_i,
    input  logic [IdWidth-1:0] commit_id_i,
    input  logic               commit_kill_i,
    output logic               result_valid_o,
    input  logic               result_ready_i,
    output logic [IdWidth-1:0] result_id_o,
    output logic [XLEN-1:0]    result_data_o,
    output logic [4:0]         result_rd_o,
    output logic               result_we_o
);

    localparam int PtrW = $clog2(Depth);
    localparam int CntW = $clog2(Latency + 1);
    localparam logic [PtrW:0] CountFull = (PtrW + 1)'(Depth);

    // Entry control state (reset) and payload (not reset)
    logic [Depth-1:0]   ent_vld_q, ent_cmt_q, ent_kill_q;
    logic [CntW-1:0]    ent_cnt_q  [Depth];
    logic [IdWidth-1:0] ent_id_q   [Depth];
    logic [4:0]         ent_rd_q   [Depth];
    logic [XLEN-1:0]    ent_data_q [Depth];
    logic               ent_we_q   [Depth];

    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PtrW:0]   count_q, count_d;

    // Decode
    logic            op_match, op_we;
    logic [1:0]      op_need;
    logic [XLEN-1:0] op_res;

    always_comb begin
        op_match = 1'b0;
        op_we    = 1'b0;
        op_need  = 2'b00;
        op_res   = '0;
        if (issue_instr_i[6:0] == 7'b1111011 && issue_instr_i[31:25] == 7'd0) begin
            unique case (issue_instr_i[14:12])
                3'b000: begin op_match = 1'b1; op_we = 1'b1; op_need = 2'b11; op_res = issue_rs1_i + issue_rs2_i; end
                3'b001: begin op_match = 1'b1; op_we = 1'b1; op_need = 2'b11; op_res = issue_rs1_i - issue_rs2_i; end
                3'b010: begin op_match = 1'b1; op_we = 1'b1; op_need = 2'b11; op_res = issue_rs1_i ^ issue_rs2_i; end
                3'b011: begin op_match = 1'b1; end
                default: ;
            endcase
        end
    end

    assign issue_ready_o     = (count_q < CountFull);
    assign issue_accept_o    = op_match && ((issue_rs_valid_i & op_need) == op_need);
    assign issue_writeback_o = issue_accept_o && op_we;

    logic push;
    assign push = issue_valid_i && issue_ready_o && issue_accept_o;

    // Commit lookup: oldest valid, still-undecided entry with a matching id,
    // scanning forward from the head so older entries win.
    logic            cm_hit, cm_new;
    logic [PtrW-1:0] cm_idx, scan_idx;

    always_comb begin
        cm_hit   = 1'b0;
        cm_idx   = '0;
        scan_idx = '0;
        for (int i = 0; i < Depth; i++) begin
            scan_idx = rd_ptr_q + PtrW'(i);
            if (!cm_hit && ent_vld_q[scan_idx] && !ent_cmt_q[scan_idx] &&
                !ent_kill_q[scan_idx] && ent_id_q[scan_idx] == commit_id_i) begin
                cm_hit = 1'b1;
                cm_idx = scan_idx;
            end
        end
    end

    // A commit that finds no buffered match may target the entry being pushed now
    assign cm_new = commit_valid_i && !cm_hit && push && (issue_id_i == commit_id_i);

    // Head: result is presented once latency elapsed and committed;
    // a killed head is dropped silently once its latency elapsed.
    logic head_done, pop;
    assign head_done      = (count_q != '0) && (ent_cnt_q[rd_ptr_q] == '0);
    assign result_valid_o = head_done && ent_cmt_q[rd_ptr_q];
    assign pop            = head_done && (ent_kill_q[rd_ptr_q] ||
                                          (ent_cmt_q[rd_ptr_q] && result_ready_i));

    assign result_id_o   = result_valid_o ? ent_id_q[rd_ptr_q]   : '0;
    assign result_data_o = result_valid_o ? ent_data_q[rd_ptr_q] : '0;
    assign result_rd_o   = result_valid_o ? ent_rd_q[rd_ptr_q]   : '0;
    assign result_we_o   = result_valid_o && ent_we_q[rd_ptr_q];

    always_comb begin
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        count_d  = count_q;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (!push && pop) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            ent_vld_q  <= '0;
            ent_cmt_q  <= '0;
            ent_kill_q <= '0;
            for (int i = 0; i < Depth; i++) ent_cnt_q[i] <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            for (int i = 0; i < Depth; i++) begin
                if (ent_cnt_q[i] != '0) ent_cnt_q[i] <= ent_cnt_q[i] - CntW'(1);
            end
            if (commit_valid_i && cm_hit) begin
                if (commit_kill_i) ent_kill_q[cm_idx] <= 1'b1;
                else               ent_cmt_q[cm_idx]  <= 1'b1;
            end
            if (pop) begin
                ent_vld_q[rd_ptr_q]  <= 1'b0;
                ent_cmt_q[rd_ptr_q]  <= 1'b0;
                ent_kill_q[rd_ptr_q] <= 1'b0;
            end
            // The push slot is always free, since push requires count < Depth.
            // The push cycle itself counts as the first execute cycle.
            if (push) begin
                ent_vld_q[wr_ptr_q]  <= 1'b1;
                ent_cmt_q[wr_ptr_q]  <= cm_new && !commit_kill_i;
                ent_kill_q[wr_ptr_q] <= cm_new && commit_kill_i;
                ent_cnt_q[wr_ptr_q]  <= CntW'(Latency - 1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            ent_id_q[wr_ptr_q]   <= issue_id_i;
            ent_rd_q[wr_ptr_q]   <= issue_instr_i[11:7];
            ent_data_q[wr_ptr_q] <= op_res;
            ent_we_q[wr_ptr_q]   <= op_we;
        end
    end

endmodule
